// File: rtl/uart_rx_core_if.sv
// Output side of the UART receiver: the buffered word, its error flags, the
// valid/ready handshake and status. The core drives it; the consumer reads it.
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  parity_err;
    logic                  framing_err;
    logic                  overrun_err;
    logic                  busy;

    modport master (
        output data_out, data_valid, parity_err, framing_err, overrun_err, busy,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, parity_err, framing_err, overrun_err, busy,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with 3-sample majority vote, optional parity,
// 1/2 stop bits and a single-entry valid/ready output buffer.
module uart_rx_core #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic           clock_i,
    input  logic           reset_n_i,
    input  logic           data_in_i,
    uart_rx_core_if.master rx_if
);
    localparam int CLKS_PER_SAMPLE = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_SAMPLE - 1);
    localparam logic [SW-1:0] S_FIRST  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_DEC    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, rx_s_q, rx_prev_q;
    logic [1:0]              warm_q;
    logic [CW-1:0]           clk_cnt_q, clk_cnt_d;
    logic [SW-1:0]           smp_cnt_q, smp_cnt_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic [1:0]              votes_q, votes_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_bad_q, par_bad_d;
    logic                    stop_bad_q, stop_bad_d;
    logic                    done_q, done_d;
    logic                    done_ferr_q, done_ferr_d;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    dvalid_q, perr_q, ferr_q, ovr_q;

    logic tick, bit_end, decide, vote, fall;

    assign tick    = (clk_cnt_q == CLK_LAST);
    assign bit_end = tick && (smp_cnt_q == S_LAST);
    assign decide  = tick && (smp_cnt_q == S_DEC);
    assign vote    = (votes_q[0] & votes_q[1]) | (votes_q[0] & rx_s_q) | (votes_q[1] & rx_s_q);
    // rx_prev_q stays 0 until the synchroniser carries real line data, so a
    // line that is already low out of reset cannot look like a start edge.
    assign fall    = rx_prev_q & ~rx_s_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            warm_q    <= 2'b00;
            rx_prev_q <= 1'b0;
        end else begin
            sync1_q   <= data_in_i;
            rx_s_q    <= sync1_q;
            warm_q    <= {warm_q[0], 1'b1};
            rx_prev_q <= warm_q[1] & rx_s_q;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            smp_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            votes_q     <= 2'b00;
            shift_q     <= '0;
            par_bad_q   <= 1'b0;
            stop_bad_q  <= 1'b0;
            done_q      <= 1'b0;
            done_ferr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            votes_q     <= votes_d;
            shift_q     <= shift_d;
            par_bad_q   <= par_bad_d;
            stop_bad_q  <= stop_bad_d;
            done_q      <= done_d;
            done_ferr_q <= done_ferr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + 1'b1;
        smp_cnt_d   = smp_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        votes_d     = votes_q;
        shift_d     = shift_q;
        par_bad_d   = par_bad_q;
        stop_bad_d  = stop_bad_q;
        done_d      = 1'b0;
        done_ferr_d = done_ferr_q;

        if (tick) begin
            clk_cnt_d = '0;
            smp_cnt_d = (smp_cnt_q == S_LAST) ? '0 : smp_cnt_q + 1'b1;
        end
        if (tick && smp_cnt_q == S_FIRST) votes_d[0] = rx_s_q;
        if (tick && smp_cnt_q == S_MID)   votes_d[1] = rx_s_q;

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d    = START;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                end
            end
            START: begin
                if (decide && vote) state_d = IDLE;
                else if (bit_end)   state_d = DATA;
            end
            DATA: begin
                if (decide) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (decide) par_bad_d = (^shift_q) ^ vote ^ (PARITY_MODE == 2);
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // Leave at the last stop bit's decision point so the next
                // start edge is seen even when frames are back to back.
                if (decide) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        done_ferr_d = stop_bad_q | ~vote;
                    end else begin
                        stop_bad_d = stop_bad_q | ~vote;
                    end
                end
                if (bit_end) stop_cnt_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE || state_d == IDLE) begin
            clk_cnt_d = '0;
            smp_cnt_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done_q) begin
                if (!dvalid_q || rx_if.data_ready) begin
                    dout_q   <= shift_q;
                    perr_q   <= par_bad_q;
                    ferr_q   <= done_ferr_q;
                    dvalid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (dvalid_q && rx_if.data_ready) begin
                dvalid_q <= 1'b0;
            end
        end
    end

    assign rx_if.data_out    = dout_q;
    assign rx_if.data_valid  = dvalid_q;
    assign rx_if.parity_err  = perr_q;
    assign rx_if.framing_err = ferr_q;
    assign rx_if.overrun_err = ovr_q;
    assign rx_if.busy        = (state_q != IDLE);
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Complete, parametrised UART receive engine. Successor to the counter-only receive datapath.
- Adds an internal control FSM, input synchronisation, 3-sample majority voting, optional parity and 1/2 stop bits.
- Reports framing, parity and overrun errors, and presents each received word through a single-entry valid/ready output buffer.
- Sits between the asynchronous rx pin and any valid/ready consumer (FIFO, bus bridge).

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bits/s
DATA_WIDTH, 8, data bits per frame; legal 5..9
OVERSAMPLE, 16, sample ticks per bit; even, >= 8
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked; 1 or 2
(derived) CLKS_PER_SAMPLE = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer divide; 54 at defaults, so 864 clocks/bit

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
data_in  input  1  serial rx line, asynchronous, idle high
data_out  output  DATA_WIDTH  received word, LSB = first bit on the line
data_valid  output  1  data_out/parity_err/framing_err hold a word
data_ready  input  1  consumer accepts the word when data_valid && data_ready
parity_err  output  1  parity mismatch for the word in data_out; 0 when PARITY_MODE = 0
framing_err  output  1  any stop bit sampled 0 for the word in data_out
overrun_err  output  1  one-cycle pulse: a completed frame was dropped
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset_n low, async):
  - FSM = IDLE; all counters = 0.
  - Synchroniser flops = 1.
  - data_out = 0; data_valid, parity_err, framing_err, overrun_err, busy = 0.
- Synchroniser: data_in passes through 2 flops; only the synchronised value (rx_s) is used. This adds 2 clocks of input latency.
- Sample tick:
  - clk_count counts 0..CLKS_PER_SAMPLE-1 and wraps; the tick fires when clk_count == CLKS_PER_SAMPLE-1.
  - sample_count counts ticks 0..OVERSAMPLE-1 and wraps; each wrap advances to the next bit.
  - Both counters are held at 0 in IDLE.
- Majority vote:
  - rx_s is captured at the ticks where sample_count = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the 2-of-3 majority, decided at the tick with sample_count = OVERSAMPLE/2+1 (the decision point).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a 1->0 transition on rx_s moves to START and clears the counters. A line low out of reset does not trigger; a high must be seen first.
  - START: vote = 1 is a false start -> IDLE, nothing delivered. Vote = 0 -> DATA at the next bit boundary.
  - DATA:
    - At each decision point, shift the vote in LSB-first.
    - bit_count runs 0..DATA_WIDTH-1.
    - After bit DATA_WIDTH-1, go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY:
    - Even mode: parity_bad = XOR(data bits, vote).
    - Odd mode: parity_bad = ~that.
    - Then STOP.
  - STOP: each stop bit is voted; any 0 sets stop_bad. At the decision point of the last stop bit, the frame completes and the FSM goes directly to IDLE (half-bit early resync, so back-to-back frames are accepted).
- Frame completion, on the cycle after the last stop decision point:
  - Buffer empty, or data_valid && data_ready in the completion cycle:
    - data_out/parity_err/framing_err load the new frame.
    - data_valid = 1.
  - Otherwise:
    - The new frame is discarded.
    - overrun_err pulses high for 1 clock.
    - Buffered contents are unchanged.
- Frames with errors are still delivered; the error flags qualify them.
- Handshake: data_valid stays high and data_out stays stable until data_valid && data_ready. data_valid falls on the next clock unless a new frame loads in that same cycle.
- data_ready while data_valid = 0 has no effect.
- Break (line held 0) produces a frame of all zeros with framing_err = 1, then waits in IDLE for rx_s to return to 1.
- busy = (state != IDLE).

Test Plan:
1. Defaults, data_ready tied 1; send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) at 864 clk/bit -> data_out = 0xA5, data_valid for 1 clock, no errors, busy low within 1 bit after stop.
2. PARITY_MODE = 1: send 0x0F with parity 0, then 0x0F with parity 1 -> parity_err = 0 on the first word, 1 on the second.
3. STOP_BITS = 2: send 0x3C with the second stop bit = 0 -> data_out = 0x3C, framing_err = 1. Line held low 20 bit-times -> a 0x00 frame with framing_err = 1, then no further frame until the line returns high.
4. Glitch: a 300-clock low pulse on the idle line -> false start, no data_valid, busy returns 0. Single-clock glitches inside a data bit at the sample points (only 1 of 3 votes corrupted) -> word unchanged.
5. data_ready held 0; send 0x11 then 0x22 back-to-back -> data_out stays 0x11, overrun_err pulses once. Raise data_ready in the exact completion cycle of a third frame 0x33 -> 0x11 consumed, 0x33 loaded, no overrun.
6. Assert reset_n low mid-DATA of frame 0x55 -> outputs 0 immediately. Release and send 0x66 -> only 0x66 delivered.
